// File: rtl/tvip_axi_read_responder.sv
// AXI read-channel responder: accepts one AR burst at a time and plays its beats
// out on R, driving a combinational memory port. Optional SLVERR checking: TVIP_AXI_READ_RESPONDER_ERROR_CHECK_EN.
module tvip_axi_read_responder #(
  parameter int ID_WIDTH      = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [ID_WIDTH-1:0]      arid,
  input  logic [ADDRESS_WIDTH-1:0] araddr,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [ID_WIDTH-1:0]      rid,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                   state_reg, state_next;
  logic                     ready_en_reg;
  logic [ID_WIDTH-1:0]      id_reg;
  logic [ADDRESS_WIDTH-1:0] addr_reg;
  logic [7:0]               len_reg;
  logic [7:0]               beat_cnt_reg;
  logic [2:0]               size_reg;
  logic [1:0]               burst_reg;
  logic [ADDRESS_WIDTH-1:0] wrap_lower_reg;
  logic [ADDRESS_WIDTH-1:0] wrap_upper_reg;

  logic                     ar_fire, r_fire, last_beat;
  logic [ADDRESS_WIDTH-1:0] size_bytes, incr_addr, next_addr;
  logic [ADDRESS_WIDTH-1:0] container, wrap_lower;

  assign ar_fire   = arvalid & arready;
  assign r_fire    = rvalid & rready;
  assign last_beat = (beat_cnt_reg == len_reg);

  // arready must stay low through reset and only rise on the first edge after release.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) ready_en_reg <= 1'b0;
    else           ready_en_reg <= 1'b1;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ar_fire) state_next = BURST;
      BURST:   if (r_fire && last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    case (state_reg)
      IDLE:  arready = ready_en_reg;
      BURST: begin
        rvalid = 1'b1;
        rlast  = last_beat;
      end
      default: ;
    endcase
  end

  // Address sequencing: INCR aligns down before stepping, so an unaligned start
  // only affects beat 0. Reserved burst types step like INCR.
  assign size_bytes = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1} << size_reg;
  assign incr_addr  = (addr_reg & ~(size_bytes - 1'b1)) + size_bytes;

  always_comb begin
    next_addr = incr_addr;
    if (burst_reg == BURST_FIXED)
      next_addr = addr_reg;
    else if (burst_reg == BURST_WRAP && incr_addr == wrap_upper_reg)
      next_addr = wrap_lower_reg;
  end

  assign container  = (ADDRESS_WIDTH'(arlen) + 1'b1) << arsize;
  assign wrap_lower = araddr & ~(container - 1'b1);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      id_reg         <= '0;
      addr_reg       <= '0;
      len_reg        <= '0;
      beat_cnt_reg   <= '0;
      size_reg       <= '0;
      burst_reg      <= '0;
      wrap_lower_reg <= '0;
      wrap_upper_reg <= '0;
    end else if (ar_fire) begin
      id_reg         <= arid;
      addr_reg       <= araddr;
      len_reg        <= arlen;
      beat_cnt_reg   <= '0;
      size_reg       <= arsize;
      burst_reg      <= arburst;
      wrap_lower_reg <= wrap_lower;
      wrap_upper_reg <= wrap_lower + container;
    end else if (r_fire && !last_beat) begin
      addr_reg     <= next_addr;
      beat_cnt_reg <= beat_cnt_reg + 8'd1;
    end
  end

  assign rid      = id_reg;
  assign mem_addr = addr_reg;

`ifdef TVIP_AXI_READ_RESPONDER_ERROR_CHECK_EN
  logic [1:0] resp_reg;
  logic       size_err, burst_err, wrap_len_err;

  assign size_err     = (9'd1 << arsize) > 9'(DATA_WIDTH / 8);
  assign burst_err    = (arburst == 2'b11);
  assign wrap_len_err = (arburst == BURST_WRAP) &&
                        !(arlen == 8'd1 || arlen == 8'd3 || arlen == 8'd7 || arlen == 8'd15);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n)    resp_reg <= RESP_OKAY;
    else if (ar_fire) resp_reg <= (size_err || burst_err || wrap_len_err) ? RESP_SLVERR : RESP_OKAY;
  end

  assign rresp = resp_reg;
  assign rdata = (resp_reg == RESP_SLVERR) ? '0 : mem_rdata;
`else
  assign rresp = RESP_OKAY;
  assign rdata = mem_rdata;
`endif

endmodule

// File: tb/tb_tvip_axi_read_responder.sv
// Scoreboard bench for tvip_axi_read_responder: expected beats are queued when a
// burst is issued and compared as R handshakes occur.
module tb_tvip_axi_read_responder;

  logic        aclk = 1'b0;
  logic        areset_n = 1'b0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  int err_cnt = 0;
  int chk_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
    logic [1:0]  resp;
    logic [3:0]  id;
  } beat_t;

  beat_t sb_q[$];

  always #5 aclk = ~aclk;

  tvip_axi_read_responder dut (
    .aclk(aclk), .areset_n(areset_n),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
    .rresp(rresp), .rlast(rlast),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]};
  endfunction

  assign mem_rdata = mem_model(mem_addr);

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [2:0] size, input logic [1:0] burst,
                                          input logic [7:0] len);
`ifdef TVIP_AXI_READ_RESPONDER_ERROR_CHECK_EN
    if ((1 << size) > 4 || burst == 2'b11 ||
        (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)))
      return 2'b10;
`endif
    return 2'b00;
  endfunction

  // Scoreboard consumer: every R handshake must match the oldest expected beat.
  always @(negedge aclk) begin
    if (areset_n && rvalid && rready) begin
      if (sb_q.size() == 0) begin
        check("stray_beat", 1, 0);
      end else begin
        beat_t e;
        e = sb_q.pop_front();
        check("mem_addr", mem_addr, e.addr);
        check("rdata", rdata, e.data);
        check("rlast", rlast, e.last);
        check("rresp", rresp, e.resp);
        check("rid", rid, e.id);
      end
    end
  end

  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall_beat, input int stall_cycles);
    logic [31:0] ea[256];
    logic [31:0] a, nb, cont, low, nxt;
    logic [1:0]  resp;
    bit          seen;
    beat_t       b;
    resp = exp_resp(size, burst, len);
    nb   = 32'd1 << size;
    cont = nb * (32'(len) + 1);
    low  = (addr / cont) * cont;
    a    = addr;
    for (int i = 0; i <= int'(len); i++) begin
      ea[i]  = a;
      b.addr = a;
      b.data = (resp == 2'b10) ? 32'h0 : mem_model(a);
      b.last = (i == int'(len));
      b.resp = resp;
      b.id   = id;
      sb_q.push_back(b);
      if (burst != 2'b00) begin
        nxt = (a / nb) * nb + nb;
        if (burst == 2'b10 && nxt == low + cont) nxt = low;
        a = nxt;
      end
    end
    $display("burst id=%0h addr=%08h len=%0d size=%0d burst=%0d resp=%0d", id, addr, len, size, burst, resp);

    @(posedge aclk); #1;
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge aclk);
      seen = arready;
    end
    if (!seen) begin
      check("ar_timeout", 0, 1);
      arvalid = 1'b0;
      return;
    end
    @(posedge aclk); #1;
    arvalid = 1'b0;

    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        rready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          @(negedge aclk);
          check("stall_rvalid", rvalid, 1);
          check("stall_addr", mem_addr, ea[i]);
          check("stall_rlast", rlast, (i == int'(len)));
          @(posedge aclk); #1;
        end
      end
      rready = 1'b1;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge aclk);
        seen = rvalid;
      end
      if (!seen) begin
        check("r_timeout", 0, 1);
        rready = 1'b0;
        return;
      end
      @(posedge aclk); #1;
    end
    rready = 1'b0;
    @(negedge aclk);
    check("bubble_rvalid", rvalid, 0);
    check("bubble_arready", arready, 1);
    check("sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    #3;
    check("rst_arready", arready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rid", rid, 0);
    check("rst_rresp", rresp, 0);
    check("rst_mem_addr", mem_addr, 0);
    #19 areset_n = 1'b1;
    #1 check("rel_arready_pre", arready, 0);
    @(posedge aclk); #1;
    check("rel_arready", arready, 1);

    run_burst(4'h1, 32'h0000_1000, 8'd3, 3'd2, 2'b01, -1, 0);
    run_burst(4'h2, 32'h0000_2008, 8'd3, 3'd2, 2'b10, -1, 0);
    run_burst(4'h3, 32'h0000_1003, 8'd1, 3'd2, 2'b01, -1, 0);
    run_burst(4'h4, 32'h0000_3000, 8'd2, 3'd2, 2'b00, 1, 3);
    run_burst(4'h5, 32'h0000_4000, 8'd1, 3'd3, 2'b01, -1, 0);
    run_burst(4'h6, 32'h0000_5000, 8'd1, 3'd2, 2'b11, -1, 0);
    run_burst(4'h7, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, -1, 0);
    run_burst(4'h8, 32'h0000_010E, 8'd7, 3'd1, 2'b10, 3, 2);
    run_burst(4'h9, 32'h0000_6000, 8'd255, 3'd0, 2'b01, 255, 1);
    for (int k = 0; k < 6; k++) begin
      logic [1:0] bt;
      logic [7:0] ln;
      bt = 2'($urandom_range(0, 2));
      ln = (bt == 2'b10) ? 8'((1 << $urandom_range(1, 4)) - 1) : 8'($urandom_range(0, 7));
      run_burst(4'($urandom), 32'($urandom_range(0, 16'hFFFF)), ln, 3'($urandom_range(0, 2)), bt,
                int'($urandom_range(0, 8)), int'($urandom_range(0, 2)));
    end

    // Reset during the second beat of a 4-beat burst.
    $display("reset mid-burst");
    @(posedge aclk); #1;
    arvalid = 1'b1; arid = 4'hA; araddr = 32'h0000_7000; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    sb_q.push_back('{32'h0000_7000, mem_model(32'h0000_7000), 1'b0, 2'b00, 4'hA});
    rready = 1'b1;
    @(negedge aclk);
    check("mid_rvalid0", rvalid, 1);
    @(posedge aclk); #1;
    rready = 1'b0;
    @(negedge aclk);
    check("mid_rvalid1", rvalid, 1);
    check("mid_addr1", mem_addr, 32'h0000_7004);
    #2 areset_n = 1'b0;
    #1;
    check("async_rvalid", rvalid, 0);
    check("async_arready", arready, 0);
    check("async_mem_addr", mem_addr, 0);
    check("async_rid", rid, 0);
    sb_q.delete();
    rready = 1'b1;
    @(negedge aclk);
    #1 areset_n = 1'b1;
    @(posedge aclk); #1;
    check("rerel_arready", arready, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      check("no_stray_rvalid", rvalid, 0);
    end
    rready = 1'b0;

    run_burst(4'hB, 32'h0000_8000, 8'd1, 3'd2, 2'b01, -1, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/tvip_axi_read_responder.md
TVIP_AXI_READ_RESPONDER -- requirements
Module: tvip_axi_read_responder

Interface
REQ-001 The module SHALL have parameter ID_WIDTH, default 4, meaning ARID/RID width.
REQ-002 The module SHALL have parameter ADDRESS_WIDTH, default 32, meaning ARADDR/mem_addr width.
REQ-003 The module SHALL have parameter DATA_WIDTH, default 32, meaning RDATA width; legal values are 8, 16, 32, 64, 128, 256, 512 and 1024.
REQ-004 The module SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port areset_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The module SHALL have the AR inputs arvalid (1), arid (ID_WIDTH), araddr (ADDRESS_WIDTH), arlen (8), arsize (3) and arburst (2); arready (1) SHALL be an output.
REQ-007 The module SHALL have the R outputs rvalid (1), rid (ID_WIDTH), rdata (DATA_WIDTH), rresp (2) and rlast (1); rready (1) SHALL be an input.
REQ-008 The module SHALL have the memory port mem_addr, output, ADDRESS_WIDTH: the current beat address; and mem_rdata, input, DATA_WIDTH: combinational read data for mem_addr.

Function
REQ-009 The module SHALL implement an FSM with states IDLE and BURST; arready = 1 only in IDLE.
REQ-010 In IDLE, on arvalid & arready the module SHALL capture arid, araddr, arlen, arsize and arburst, and SHALL enter BURST on the next cycle with rvalid = 1.
REQ-011 In BURST, rvalid SHALL stay 1, and rid, rresp, rlast and mem_addr SHALL stay stable, until rvalid & rready.
REQ-012 The beat count SHALL be arlen + 1 (1..256); rlast = 1 only on the final beat.
REQ-013 On the final-beat handshake the FSM SHALL return to IDLE: rvalid = 0 and arready = 1 the following cycle, so there is exactly one bubble between bursts.
REQ-014 rdata SHALL equal mem_rdata while rresp = OKAY, and SHALL be all zeros while rresp = SLVERR.
REQ-015 The beat-0 mem_addr SHALL be araddr unmodified (unaligned start is allowed).
REQ-016 For FIXED (2'b00) bursts, mem_addr SHALL be unchanged for all beats.
REQ-017 For INCR (2'b01) bursts, the next address SHALL be (current address aligned down to 2^arsize) + 2^arsize, truncated to ADDRESS_WIDTH (wraps modulo 2^ADDRESS_WIDTH).
REQ-018 For WRAP (2'b10) bursts, with container = 2^arsize * (arlen+1) and lower = araddr aligned down to container, the next address SHALL be the INCR value, replaced by lower when it reaches lower + container.
REQ-019 rresp SHALL be constant across all beats of a burst, and SHALL never be EXOKAY or DECERR.

Reset
REQ-020 While areset_n = 0 the module SHALL force: state IDLE, arready = 0, rvalid = 0, rlast = 0, rid = 0, rresp = 0, mem_addr = 0.
REQ-021 arready SHALL rise to 1 on the first aclk edge after areset_n deasserts.
REQ-022 An assertion of areset_n mid-burst SHALL abandon the burst immediately (rvalid = 0 asynchronously); no residual beats SHALL follow reset release.

Configuration
REQ-023 Macro TVIP_AXI_READ_RESPONDER_ERROR_CHECK_EN SHALL control burst error checking.
REQ-024 With TVIP_AXI_READ_RESPONDER_ERROR_CHECK_EN defined, rresp SHALL be SLVERR (2'b10) for the whole burst if any of the following holds: 2^arsize > DATA_WIDTH/8; arburst = 2'b11; WRAP with arlen+1 not in {2,4,8,16}.
REQ-025 With the error conditions of REQ-024 and the macro defined, the address still SHALL sequence per REQ-015..REQ-018, with reserved arburst sequencing as INCR.
REQ-026 Without the macro, rresp SHALL always be OKAY, arburst = 2'b11 SHALL be treated as INCR, and no error logic SHALL be synthesised.

Verification
REQ-027 INCR, araddr=0x1000, arlen=3, arsize=2, rready=1 -> 4 beats on consecutive cycles at mem_addr 0x1000, 0x1004, 0x1008, 0x100C; rlast on beat 4; all rresp OKAY.
REQ-028 WRAP, araddr=0x2008, arlen=3, arsize=2 -> mem_addr 0x2008, 0x200C, 0x2000, 0x2004.
REQ-029 INCR, araddr=0x1003, arlen=1, arsize=2 -> mem_addr 0x1003, then 0x1004.
REQ-030 FIXED, arlen=2, with rready low for 3 cycles on beat 2 -> beat 2 held stable; 3 beats total at the same address.
REQ-031 With the macro defined, DATA_WIDTH=32, arsize=3, arlen=1 -> 2 beats, each rresp=2'b10 and rdata=0; without the macro -> rresp=OKAY.
REQ-032 Assert areset_n low during beat 2 of a 4-beat burst -> rvalid=0 at once; after release, arready=1 next edge and no stray beats.
